// File: rtl/edge_implication_monitor.sv
// Clocked implication monitor "a |-> edge(b)" with pass/fail(/vacuous) pulses,
// saturating counters and a first-fail cycle stamp. Optional macro: EDGE_MON_VACUOUS_EN.
module edge_implication_monitor #(
  parameter int CNT_W        = 16,
  parameter int TS_W         = 32,
  parameter int HALT_ON_FAIL = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             clr,
  input  logic [1:0]       edge_sel,
  input  logic             a,
  input  logic             b,
  output logic             pass,
  output logic             fail,
  output logic             vacuous,
  output logic [CNT_W-1:0] pass_cnt,
  output logic [CNT_W-1:0] fail_cnt,
  output logic [CNT_W-1:0] vac_cnt,
  output logic [TS_W-1:0]  first_fail_ts,
  output logic             first_fail_vld,
  output logic             halted
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_HALT = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    E_FELL    = 2'd0,
    E_ROSE    = 2'd1,
    E_STABLE  = 2'd2,
    E_CHANGED = 2'd3
  } edge_t;

  state_t            r_state, w_state_nxt;
  logic              r_b_past;
  logic [TS_W-1:0]   r_cyc;
  logic              r_pass, r_fail;
  logic [CNT_W-1:0]  r_pass_cnt, r_fail_cnt;
  logic [TS_W-1:0]   r_ff_ts;
  logic              r_ff_vld;

  logic              w_edge_true;
  logic              w_eval;
  logic              w_pass, w_fail, w_vac;

  always_comb begin
    w_edge_true = 1'b0;
    case (edge_t'(edge_sel))
      E_FELL:    w_edge_true = r_b_past & ~b;
      E_ROSE:    w_edge_true = ~r_b_past & b;
      E_STABLE:  w_edge_true = (b == r_b_past);
      E_CHANGED: w_edge_true = (b != r_b_past);
      default:   w_edge_true = 1'b0;
    endcase
  end

  // An evaluation in a clr cycle is discarded; IDLE with en=1 evaluates on the same edge.
  assign w_eval = en & ~clr & (r_state != S_HALT);
  assign w_fail = w_eval & a & ~w_edge_true;
`ifdef EDGE_MON_VACUOUS_EN
  assign w_pass = w_eval & a & w_edge_true;
  assign w_vac  = w_eval & ~a;
`else
  assign w_pass = w_eval & (~a | w_edge_true);
  assign w_vac  = 1'b0;
`endif

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (en)  w_state_nxt = S_RUN;
      S_RUN:   if (!en) w_state_nxt = S_IDLE;
      S_HALT:  w_state_nxt = S_HALT;
      default: w_state_nxt = S_IDLE;
    endcase
    if (w_fail && (HALT_ON_FAIL != 0)) w_state_nxt = S_HALT;
    if (clr)                           w_state_nxt = S_IDLE;
  end

  // NOTE: all state updates use non-blocking assignments with a synchronous reset check first,
  // so every register sees the pre-edge values of its neighbours.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_b_past   <= 1'b0;
      r_cyc      <= '0;
      r_pass     <= 1'b0;
      r_fail     <= 1'b0;
      r_pass_cnt <= '0;
      r_fail_cnt <= '0;
      r_ff_ts    <= '0;
      r_ff_vld   <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_b_past <= b;
      r_cyc    <= r_cyc + 1'b1;
      r_pass   <= w_pass;
      r_fail   <= w_fail;
      if (clr) begin
        r_pass_cnt <= '0;
        r_fail_cnt <= '0;
        r_ff_ts    <= '0;
        r_ff_vld   <= 1'b0;
      end else begin
        if (w_pass && (r_pass_cnt != {CNT_W{1'b1}})) r_pass_cnt <= r_pass_cnt + 1'b1;
        if (w_fail && (r_fail_cnt != {CNT_W{1'b1}})) r_fail_cnt <= r_fail_cnt + 1'b1;
        if (w_fail && !r_ff_vld) begin
          r_ff_ts  <= r_cyc;
          r_ff_vld <= 1'b1;
        end
      end
    end
  end

`ifdef EDGE_MON_VACUOUS_EN
  logic             r_vac;
  logic [CNT_W-1:0] r_vac_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_vac     <= 1'b0;
      r_vac_cnt <= '0;
    end else begin
      r_vac <= w_vac;
      if (clr)                                        r_vac_cnt <= '0;
      else if (w_vac && (r_vac_cnt != {CNT_W{1'b1}})) r_vac_cnt <= r_vac_cnt + 1'b1;
    end
  end

  assign vacuous = r_vac;
  assign vac_cnt = r_vac_cnt;
`else
  assign vacuous = w_vac;
  assign vac_cnt = '0;
`endif

  assign pass           = r_pass;
  assign fail           = r_fail;
  assign pass_cnt       = r_pass_cnt;
  assign fail_cnt       = r_fail_cnt;
  assign first_fail_ts  = r_ff_ts;
  assign first_fail_vld = r_ff_vld;
  assign halted         = (r_state == S_HALT);

endmodule

// File: tb/tb_edge_implication_monitor.sv
// Bench for edge_implication_monitor: three instances (default, CNT_W=2, HALT_ON_FAIL=1)
// share one stimulus and are checked every cycle against a rule-level model plus literal points.
module tb_edge_implication_monitor;

  logic       clk = 1'b0;
  logic       rst, en, clr, a, b;
  logic [1:0] edge_sel;

  always #5 clk = ~clk;

  logic        p0, f0, v0, vld0, h0;
  logic [15:0] pc0, fc0, vc0;
  logic [31:0] ts0;
  logic        p1, f1, v1, vld1, h1;
  logic [1:0]  pc1, fc1, vc1;
  logic [31:0] ts1;
  logic        p2, f2, v2, vld2, h2;
  logic [15:0] pc2, fc2, vc2;
  logic [31:0] ts2;

  edge_implication_monitor u0 (
    .clk(clk), .rst(rst), .en(en), .clr(clr), .edge_sel(edge_sel), .a(a), .b(b),
    .pass(p0), .fail(f0), .vacuous(v0), .pass_cnt(pc0), .fail_cnt(fc0), .vac_cnt(vc0),
    .first_fail_ts(ts0), .first_fail_vld(vld0), .halted(h0));

  edge_implication_monitor #(.CNT_W(2)) u1 (
    .clk(clk), .rst(rst), .en(en), .clr(clr), .edge_sel(edge_sel), .a(a), .b(b),
    .pass(p1), .fail(f1), .vacuous(v1), .pass_cnt(pc1), .fail_cnt(fc1), .vac_cnt(vc1),
    .first_fail_ts(ts1), .first_fail_vld(vld1), .halted(h1));

  edge_implication_monitor #(.HALT_ON_FAIL(1)) u2 (
    .clk(clk), .rst(rst), .en(en), .clr(clr), .edge_sel(edge_sel), .a(a), .b(b),
    .pass(p2), .fail(f2), .vacuous(v2), .pass_cnt(pc2), .fail_cnt(fc2), .vac_cnt(vc2),
    .first_fail_ts(ts2), .first_fail_vld(vld2), .halted(h2));

`ifdef EDGE_MON_VACUOUS_EN
  localparam bit VAC_ON = 1'b1;
`else
  localparam bit VAC_ON = 1'b0;
`endif

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Model: evaluation happens whenever en is high, the instance is not halted and clr is low.
  longint m_max[3] = '{65535, 3, 65535};
  bit     m_hof[3] = '{1'b0, 1'b0, 1'b1};
  bit     m_p[3], m_f[3], m_v[3], m_vld[3], m_h[3];
  longint m_pc[3], m_fc[3], m_vc[3], m_ts[3];
  bit     m_bp;
  longint m_cyc;
  bit     started = 1'b0;

  task automatic model_step();
    bit ok;
    case (edge_sel)
      2'd0:    ok = m_bp && !b;
      2'd1:    ok = !m_bp && b;
      2'd2:    ok = (m_bp == b);
      default: ok = (m_bp != b);
    endcase
    for (int k = 0; k < 3; k++) begin
      m_p[k] = 0; m_f[k] = 0; m_v[k] = 0;
      if (rst) begin
        m_pc[k] = 0; m_fc[k] = 0; m_vc[k] = 0; m_ts[k] = 0; m_vld[k] = 0; m_h[k] = 0;
      end else if (clr) begin
        m_pc[k] = 0; m_fc[k] = 0; m_vc[k] = 0; m_ts[k] = 0; m_vld[k] = 0; m_h[k] = 0;
      end else if (en && !m_h[k]) begin
        if (!a && VAC_ON) m_v[k] = 1;
        else if (!a || ok) m_p[k] = 1;
        else m_f[k] = 1;
        if (m_p[k]) m_pc[k] = (m_pc[k] < m_max[k]) ? m_pc[k] + 1 : m_max[k];
        if (m_f[k]) m_fc[k] = (m_fc[k] < m_max[k]) ? m_fc[k] + 1 : m_max[k];
        if (m_v[k]) m_vc[k] = (m_vc[k] < m_max[k]) ? m_vc[k] + 1 : m_max[k];
        if (m_f[k] && !m_vld[k]) begin m_ts[k] = m_cyc; m_vld[k] = 1; end
        if (m_f[k] && m_hof[k]) m_h[k] = 1;
      end
    end
    if (rst) begin
      m_bp = 0; m_cyc = 0; started = 1'b1;
    end else begin
      m_bp = b; m_cyc = (m_cyc + 1) & 64'hFFFF_FFFF;
    end
  endtask

  task automatic cmp(input int k, input logic p, f, v, input logic [63:0] pc, fc, vc, ts,
                     input logic vld, h);
    check($sformatf("u%0d.pass", k), {63'd0, p}, {63'd0, m_p[k]});
    check($sformatf("u%0d.fail", k), {63'd0, f}, {63'd0, m_f[k]});
    check($sformatf("u%0d.vacuous", k), {63'd0, v}, {63'd0, m_v[k]});
    check($sformatf("u%0d.pass_cnt", k), pc, m_pc[k]);
    check($sformatf("u%0d.fail_cnt", k), fc, m_fc[k]);
    check($sformatf("u%0d.vac_cnt", k), vc, m_vc[k]);
    check($sformatf("u%0d.first_fail_ts", k), ts, m_ts[k]);
    check($sformatf("u%0d.first_fail_vld", k), {63'd0, vld}, {63'd0, m_vld[k]});
    check($sformatf("u%0d.halted", k), {63'd0, h}, {63'd0, m_h[k]});
  endtask

  initial begin
    forever begin
      @(posedge clk);
      model_step();
      #1;
      if (started) begin
        cmp(0, p0, f0, v0, 64'(pc0), 64'(fc0), 64'(vc0), 64'(ts0), vld0, h0);
        cmp(1, p1, f1, v1, 64'(pc1), 64'(fc1), 64'(vc1), 64'(ts1), vld1, h1);
        cmp(2, p2, f2, v2, 64'(pc2), 64'(fc2), 64'(vc2), 64'(ts2), vld2, h2);
      end
    end
  end

  task automatic step(input logic r, e, c, input logic [1:0] s, input logic av, bv);
    rst = r; en = e; clr = c; edge_sel = s; a = av; b = bv;
    @(negedge clk);
  endtask

  task automatic do_reset();
    step(1, 0, 0, 2'd0, 0, 0);
    step(1, 0, 0, 2'd0, 0, 0);
  endtask

  initial begin
    rst = 1; en = 0; clr = 0; edge_sel = 0; a = 0; b = 0;
    @(negedge clk);
    do_reset();
    check("reset.pass_cnt", 64'(pc0), 0);
    check("reset.first_fail_vld", {63'd0, vld0}, 0);

    // fell with the reference sequence
    step(0, 1, 0, 2'd0, 0, 1);
    step(0, 1, 0, 2'd0, 1, 0);
    step(0, 1, 0, 2'd0, 1, 1);
    step(0, 1, 0, 2'd0, 0, 0);
    for (int i = 0; i < 8; i++) step(0, 1, 0, 2'd0, 1, 1);
    check("seq.pass_cnt", 64'(pc0), VAC_ON ? 1 : 3);
    check("seq.fail_cnt", 64'(fc0), 9);
    check("seq.vac_cnt", 64'(vc0), VAC_ON ? 2 : 0);
    check("seq.first_fail_ts", 64'(ts0), 2);

    // first sample after reset compares against b_past=0
    do_reset();
    step(0, 1, 0, 2'd0, 1, 0);
    check("first_fell.fail", {63'd0, f0}, 1);
    do_reset();
    step(0, 1, 0, 2'd2, 1, 0);
    check("first_stable.pass", {63'd0, p0}, 1);

    // saturation on the narrow instance
    do_reset();
    for (int i = 0; i < 6; i++) step(0, 1, 0, 2'd3, 1, (i % 2 == 0));
    check("sat.u1.pass_cnt", 64'(pc1), 3);
    check("sat.u0.pass_cnt", 64'(pc0), 6);
    check("sat.u1.fail_cnt", 64'(fc1), 0);

    // halt on first fail at cyc=4, then clr
    do_reset();
    for (int i = 0; i < 4; i++) step(0, 1, 0, 2'd0, 0, 0);
    step(0, 1, 0, 2'd0, 1, 0);
    check("halt.fail", {63'd0, f2}, 1);
    check("halt.halted", {63'd0, h2}, 1);
    check("halt.first_fail_ts", 64'(ts2), 4);
    step(0, 1, 0, 2'd0, 1, 1);
    step(0, 1, 0, 2'd0, 1, 1);
    check("halt.frozen.fail", {63'd0, f2}, 0);
    check("halt.frozen.pass", {63'd0, p2}, 0);
    step(0, 1, 1, 2'd0, 1, 1);
    check("clr.halted", {63'd0, h2}, 0);
    check("clr.fail_cnt", 64'(fc2), 0);
    check("clr.first_fail_vld", {63'd0, vld2}, 0);
    step(0, 1, 0, 2'd0, 1, 0);
    check("after_clr.pass", {63'd0, p2}, 1);

    // en gaps and reset mid-run
    do_reset();
    step(0, 1, 0, 2'd0, 1, 1);
    step(0, 1, 0, 2'd0, 1, 1);
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 0, 2'd0, 1, 1);
      check("en_low.fail", {63'd0, f0}, 0);
    end
    step(0, 1, 0, 2'd0, 1, 1);
    step(0, 1, 0, 2'd0, 1, 1);
    step(0, 1, 0, 2'd0, 1, 1);
    check("midrun.fail_cnt", 64'(fc0), 5);
    step(1, 1, 1, 2'd0, 1, 1);
    check("rst.fail_cnt", 64'(fc0), 0);
    check("rst.fail", {63'd0, f0}, 0);
    check("rst.first_fail_ts", 64'(ts0), 0);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 2'd0, 1, 1);
    step(0, 1, 0, 2'd0, 1, 1);
    check("cyc_counts.first_fail_ts", 64'(ts0), 3);

    // mixed edge_sel / en / clr traffic
    for (int i = 0; i < 48; i++)
      step(0, (i % 9) != 8, (i == 20) || (i == 37), 2'(i % 4), (i % 3) != 0, ((i * 5) % 7) < 3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
